// File: rtl/spi_flash_sim_xip.sv
// SPI NOR flash bench model for XIP boot simulation.
// Pins are sampled in the clk_i domain. Supported opcodes: READ (03),
// FAST_READ (0B), RDSR (05) and JEDEC-ID (9F). Every other opcode is ignored
// and flagged on err_cmd_o.
module spi_flash_sim_xip #(
    parameter int unsigned ADDR_BYTES    = 3,
    parameter int unsigned MEM_ADDR_BITS = 8,
    parameter string       MEM_INIT      = "",
    parameter int unsigned DUMMY_CLKS    = 8,
    parameter logic [23:0] JEDEC_ID      = 24'hEF4017,
    parameter logic [7:0]  STATUS        = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_cs_i,
    input  logic       spi_sck_i,
    input  logic       spi_si_i,
    output logic       spi_so_o,
    output logic       txn_done_o,
    output logic       err_cmd_o,
    output logic [7:0] last_cmd_o
);
    localparam int unsigned DEPTH      = 2 ** MEM_ADDR_BITS;
    localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BYTES * 8 - 1);
    localparam logic [7:0]  DUMMY_LAST = 8'((DUMMY_CLKS == 0) ? 0 : DUMMY_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_RESP, S_IGNORE
    } state_t;

    // Byte-wide backing store. It is never written by the design, only
    // preloaded, and reset leaves its contents alone.
    logic [7:0] mem [DEPTH];

    // Preload: erased flash (all FF).
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'hFF;
    end

    logic [1:0] cs_sync_q, sck_sync_q, si_sync_q;
    logic       cs_prev_q, sck_prev_q;
    logic       cs_s, si_s, sck_rise, sck_fall;

    // Two-stage synchronisers plus one history stage for edge detection.
    // cs history resets low so a frame already in progress at reset release
    // never looks like a fresh cs fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_q  <= '0;
            sck_sync_q <= '0;
            si_sync_q  <= '0;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[0], spi_cs_i};
            sck_sync_q <= {sck_sync_q[0], spi_sck_i};
            si_sync_q  <= {si_sync_q[0], spi_si_i};
            cs_prev_q  <= cs_sync_q[1];
            sck_prev_q <= sck_sync_q[1];
        end
    end

    assign cs_s     = cs_sync_q[1];
    assign si_s     = si_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[1] & sck_prev_q;

    state_t                   state_q, state_d;
    logic [7:0]               bit_cnt_q, bit_cnt_d;
    logic [6:0]               cmd_sr_q, cmd_sr_d;
    logic [7:0]               last_cmd_q, last_cmd_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d, addr_sh, addr_inc;
    logic [7:0]               tx_q, tx_d;
    logic [2:0]               tx_cnt_q, tx_cnt_d;
    logic [1:0]               resp_cnt_q, resp_cnt_d;
    logic                     so_q, so_d, done_q, done_d, err_q, err_d;
    logic [7:0]               cmd_byte;

    // Only the low MEM_ADDR_BITS of the address are kept, so the address is
    // taken modulo the depth for free and 4-byte mode needs no extra logic.
    assign addr_sh  = {addr_q[MEM_ADDR_BITS-2:0], si_s};
    assign addr_inc = addr_q + 1'b1;
    assign cmd_byte = {cmd_sr_q, si_s};

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            cmd_sr_q   <= '0;
            last_cmd_q <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            tx_cnt_q   <= '0;
            resp_cnt_q <= '0;
            so_q       <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            last_cmd_q <= last_cmd_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            so_q       <= so_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. cs high is checked first so it beats any sck edge
    // seen in the same synced cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        last_cmd_d = last_cmd_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        tx_cnt_d   = tx_cnt_q;
        resp_cnt_d = resp_cnt_q;
        so_d       = so_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (cs_s) begin
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                so_d    = 1'b1;
                done_d  = (state_q == S_ADDR) || (state_q == S_DUMMY) ||
                          (state_q == S_DATA) || (state_q == S_RESP);
            end
        end else begin
            case (state_q)
                S_IDLE: if (cs_prev_q) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    so_d      = 1'b1;
                end
                S_CMD: if (sck_rise) begin
                    cmd_sr_d  = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == 8'd7) begin
                        last_cmd_d = cmd_byte;
                        bit_cnt_d  = '0;
                        tx_cnt_d   = '0;
                        case (cmd_byte)
                            8'h03, 8'h0B: state_d = S_ADDR;
                            8'h05: begin
                                state_d = S_RESP;
                                tx_d    = STATUS;
                            end
                            8'h9F: begin
                                state_d    = S_RESP;
                                tx_d       = JEDEC_ID[23:16];
                                resp_cnt_d = 2'd1;
                            end
                            default: begin
                                state_d = S_IGNORE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: if (sck_rise) begin
                    addr_d    = addr_sh;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        if (last_cmd_q == 8'h0B && DUMMY_CLKS != 0) begin
                            state_d = S_DUMMY;
                        end else begin
                            state_d = S_DATA;
                            tx_d    = mem[addr_sh];
                        end
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == DUMMY_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                        tx_d      = mem[addr_q];
                    end
                end
                S_DATA, S_RESP: if (sck_fall) begin
                    so_d = tx_q[7];
                    if (tx_cnt_q == 3'd7) begin
                        tx_cnt_d = '0;
                        if (state_q == S_DATA) begin
                            addr_d = addr_inc;
                            tx_d   = mem[addr_inc];
                        end else if (last_cmd_q == 8'h05) begin
                            tx_d = STATUS;
                        end else begin
                            case (resp_cnt_q)
                                2'd1:    tx_d = JEDEC_ID[15:8];
                                2'd2:    tx_d = JEDEC_ID[7:0];
                                default: tx_d = 8'h00;
                            endcase
                            if (resp_cnt_q != 2'd3) resp_cnt_d = resp_cnt_q + 2'd1;
                        end
                    end else begin
                        tx_d     = {tx_q[6:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign spi_so_o   = so_q;
    assign txn_done_o = done_q;
    assign err_cmd_o  = err_q;
    assign last_cmd_o = last_cmd_q;
endmodule

// File: tb/tb_spi_flash_sim_xip.sv
// Bench for spi_flash_sim_xip: directed scenarios plus random transactions
// checked against a byte-level model of the flash's command set.
module tb_spi_flash_sim_xip;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs  = 1'b1;
    logic       sck = 1'b0;
    logic       si  = 1'b0;
    logic       so, done, err;
    logic [7:0] last_cmd;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [7:0] mem_m [256];

    spi_flash_sim_xip dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_cs_i   (cs),
        .spi_sck_i  (sck),
        .spi_si_i   (si),
        .spi_so_o   (so),
        .txn_done_o (done),
        .err_cmd_o  (err),
        .last_cmd_o (last_cmd)
    );

    always #5 clk = ~clk;

    // Count pulse cycles; a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI master, mode 0, SCK = clk/8; MISO sampled at the SCK rise.
    task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            si = mosi[i];
            #40 sck = 1'b1;
            miso[i] = so;
            #40 sck = 1'b0;
        end
    endtask

    // Expected MISO byte i of the data/response phase.
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] a, input int i);
        logic [7:0] idx;
        logic [23:0] jid;
        idx = a[7:0] + 8'(i);
        jid = 24'hEF4017;
        case (op)
            8'h03, 8'h0B: return mem_m[idx];
            8'h05:        return 8'h00;
            8'h9F:        return (i < 3) ? jid[23 - 8*i -: 8] : 8'h00;
            default:      return 8'hFF;
        endcase
    endfunction

    function automatic bit known(input logic [7:0] op);
        return op == 8'h03 || op == 8'h0B || op == 8'h05 || op == 8'h9F;
    endfunction

    task automatic txn(input logic [7:0] op, input logic [23:0] a, input int nb, input string tag);
        logic [7:0] rx;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        cs = 1'b0;
        #40;
        xfer(op, 8, rx);
        chk({tag, " cmd so"}, rx, 8'hFF);
        if (op == 8'h03 || op == 8'h0B) begin
            for (int b = 2; b >= 0; b--) begin
                xfer(a[8*b +: 8], 8, rx);
                chk({tag, " addr so"}, rx, 8'hFF);
            end
            if (op == 8'h0B) begin
                xfer(8'($urandom), 8, rx);
                chk({tag, " dummy so"}, rx, 8'hFF);
            end
        end
        for (int i = 0; i < nb; i++) begin
            xfer(8'($urandom), 8, rx);
            chk({tag, " data"}, rx, model_byte(op, a, i));
        end
        #40 cs = 1'b1;
        #100;
        chk({tag, " last_cmd"}, last_cmd, op);
        chk({tag, " done"}, done_cnt - d0, known(op) ? 1 : 0);
        chk({tag, " err"}, err_cnt - e0, known(op) ? 0 : 1);
        chk({tag, " idle so"}, so, 1'b1);
    endtask

    initial begin
        logic [7:0] rx, op;
        int d0;
        #1;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
        mem_m[8'h10] = 8'hA5;
        mem_m[8'h11] = 8'h5A;
        mem_m[8'hFF] = 8'h11;
        mem_m[8'h00] = 8'h22;
        for (int i = 0; i < 256; i++) dut.mem[i] = mem_m[i];
        #59;
        chk("rst so", so, 1'b1);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst last_cmd", last_cmd, 8'h00);
        rst = 1'b0;
        #100;

        txn(8'h03, 24'h000010, 2, "read");
        txn(8'h0B, 24'h000010, 1, "fast");
        txn(8'h03, 24'h0000FF, 2, "wrap");
        txn(8'h9F, 24'h0, 5, "jedec");
        txn(8'h05, 24'h0, 2, "rdsr");
        txn(8'h77, 24'h0, 2, "bad op");
        txn(8'h03, 24'h000010, 1, "after bad");

        // Abort after 12 address bits: still a recognised command.
        d0 = done_cnt;
        cs = 1'b0;
        #40;
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 4, rx);
        #40 cs = 1'b1;
        #100;
        chk("abort done", done_cnt - d0, 1);
        txn(8'h03, 24'h000010, 1, "post abort");

        // Reset mid-DATA with cs held low: no output until cs toggles.
        d0 = done_cnt;
        cs = 1'b0;
        #40;
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h10, 8, rx);
        xfer(8'h00, 4, rx);
        chk("pre-rst nibble", rx[7:4], 4'hA);
        rst = 1'b1;
        #30 rst = 1'b0;
        xfer(8'h00, 8, rx);
        chk("post-rst so", rx, 8'hFF);
        xfer(8'h00, 8, rx);
        chk("post-rst so2", rx, 8'hFF);
        #40 cs = 1'b1;
        #100;
        chk("post-rst done", done_cnt - d0, 0);
        chk("post-rst last_cmd", last_cmd, 8'h00);
        txn(8'h03, 24'h000010, 2, "rst recover");

        // Random transactions.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h03;
                1: op = 8'h0B;
                2: op = 8'h05;
                3: op = 8'h9F;
                default: begin
                    op = 8'($urandom);
                    while (known(op)) op = 8'($urandom);
                end
            endcase
            txn(op, 24'($urandom), $urandom_range(1, 5), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
